softmax_job_scheduler: RTL and testbench
========================================

// Module: softmax_job_scheduler
// PURPOSE
//   Shares one BRAM_FSM/softmax pipeline between N_REQ requesters. Arbitrates
//   pending jobs round-robin and latches the winner's depth. Issues the start
//   pulse, then tracks the engine's busy handshake to completion.
//   Signals done or error per requester, and guards against a hung engine with
//   ack and run watchdogs.
// PARAMETERS
//   N_REQ        4     number of requesters (>=2)
//   DEPTH_W      8     width of job depth (last row index, inclusive)
//   ACK_TIMEOUT  4     max cycles from o_start to i_busy rising
//   RUN_TIMEOUT  1024  max cycles i_busy may stay high
// PORTS
//   i_clk         in   1               clock
//   i_rst_n       in   1               synchronous reset, active-low
//   i_en          in   1               clock enable; low freezes all state
//   i_req         in   N_REQ           per-requester job request (level)
//   i_req_depth   in   N_REQ*DEPTH_W   flat depths; slice k = requester k
//   o_grant       out  N_REQ           one-hot owner of the engine
//   o_done        out  N_REQ           one-cycle completion pulse to owner
//   o_err         out  1               high with o_done when job aborted
//   o_err_sticky  out  1               set on any abort; cleared by i_clr_err
//   i_clr_err     in   1               clears o_err_sticky
//   o_start       out  1               start pulse to BRAM_FSM
//   o_depth       out  DEPTH_W         depth to BRAM_FSM, held while granted
//   i_busy        in   1               BRAM_FSM busy
// BEHAVIOUR
//   Reset (i_rst_n=0 at edge): state IDLE, all outputs 0, RR pointer=N_REQ-1.
//   Reset mid-job aborts silently: no o_done is issued.
//   i_en=0: no state, counter or pointer change. o_start/o_done/o_err are
//     gated by i_en, so a pulse is emitted exactly once, in an enabled cycle.
//   FSM states:
//   IDLE:  if |i_req, pick the first set bit searching from ptr+1 (wrapping).
//          Latch idx and depth; o_grant[idx]<=1 -> START.
//   START: o_start=1 for one cycle; clear counter -> WAIT.
//   WAIT:  if i_busy -> RUN (clear counter).
//          Else if counter==ACK_TIMEOUT-1 -> ERR. Else counter++.
//   RUN:   if !i_busy -> DONE.
//          Else if counter==RUN_TIMEOUT-1 -> ERR. Else counter++.
//   DONE:  o_done[idx]=1; grant cleared; ptr<=idx -> IDLE.
//   ERR:   o_done[idx]=1 and o_err=1; o_err_sticky<=1; grant cleared;
//          ptr<=idx -> IDLE.
//   Latency: req seen in IDLE -> o_start 2 cycles later (grant, then start).
//   After DONE, the next grant comes 1 cycle later (IDLE re-arbitrates).
//   Requester must hold i_req until its o_done. Depth is sampled only at grant,
//     so later depth changes are ignored. Dropping i_req while granted has no
//     effect on the current job.
//   Simultaneous i_clr_err and an ERR entry: the set wins.
//   o_depth keeps its last value when idle. o_grant is never multi-hot.
//   Counters are saturating-free: width = clog2(max timeout).
//   Counters never exceed their timeout values.
// TESTING
//   1. Single req[2], depth=8'd15; model raises busy 2 cyc after start and
//      holds it 20 cyc -> o_start once, o_depth=15, o_done[2] once, o_err=0.
//   2. i_req=4'b1111 held, ptr reset -> grants in order 0,1,2,3,0.
//      Each grant begins exactly 1 cycle after the previous o_done.
//   3. Engine never raises busy -> ERR 4 cycles after o_start.
//      o_done[k]=o_err=1; o_err_sticky=1 until i_clr_err pulse.
//   4. Busy stuck high -> abort at RUN_TIMEOUT (1024 cyc).
//      Next requester is then granted normally.
//   5. Toggle i_en low 3 cycles during START and RUN.
//      -> exactly one o_start and one o_done; timeout counts only enabled
//      cycles.
//   6. Assert i_rst_n=0 during RUN -> all outputs 0 next cycle, no o_done.
//      ptr=N_REQ-1 afterwards.

Source files
------------

// File: rtl/softmax_job_scheduler.sv
// Round-robin scheduler sharing one BRAM_FSM/softmax engine between N_REQ requesters,
// with start/busy handshake tracking and ack/run watchdogs.
module softmax_job_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DEPTH_W     = 8,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned RUN_TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DEPTH_W-1:0]   i_req_depth,
  output logic [N_REQ-1:0]           o_grant,
  output logic [N_REQ-1:0]           o_done,
  output logic                       o_err,
  output logic                       o_err_sticky,
  input  logic                       i_clr_err,
  output logic                       o_start,
  output logic [DEPTH_W-1:0]         o_depth,
  input  logic                       i_busy
);

  localparam int unsigned MaxTimeout = (ACK_TIMEOUT > RUN_TIMEOUT) ? ACK_TIMEOUT : RUN_TIMEOUT;
  localparam int unsigned CntW       = (MaxTimeout > 1) ? $clog2(MaxTimeout) : 1;
  localparam int unsigned IdxW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CntW-1:0] AckLast = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0] RunLast = CntW'(RUN_TIMEOUT - 1);
  localparam logic [IdxW-1:0] PtrRst  = IdxW'(N_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StRun,
    StDone,
    StErr
  } state_e;

  state_e               r_state;
  logic [IdxW-1:0]      r_ptr;
  logic [IdxW-1:0]      r_idx;
  logic [CntW-1:0]      r_cnt;
  logic [N_REQ-1:0]     r_grant;
  logic [N_REQ-1:0]     r_done;
  logic                 r_err;
  logic                 r_err_sticky;
  logic                 r_start;
  logic [DEPTH_W-1:0]   r_depth;

  logic [N_REQ-1:0]     w_mask;
  logic [N_REQ-1:0]     w_req_hi;
  logic [IdxW-1:0]      w_pick;
  logic [N_REQ-1:0]     w_pick_oh;
  logic [DEPTH_W-1:0]   w_pick_depth;

  function automatic logic [IdxW-1:0] f_lowest(input logic [N_REQ-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  // Requests above the pointer take priority; otherwise wrap to the lowest set bit.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_mask[i] = (i > int'(r_ptr));
    end
    w_req_hi = i_req & w_mask;
    w_pick   = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(i_req);
    w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  end

  always_comb begin
    w_pick_depth = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IdxW'(k) == w_pick) w_pick_depth = i_req_depth[k*DEPTH_W +: DEPTH_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_ptr        <= PtrRst;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_start      <= 1'b0;
      r_depth      <= '0;
    end else if (i_en) begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= 1'b0;
      if (i_clr_err) r_err_sticky <= 1'b0;
      case (r_state)
        StIdle: begin
          if (|i_req) begin
            r_idx   <= w_pick;
            r_depth <= w_pick_depth;
            r_grant <= w_pick_oh;
            r_state <= StStart;
          end
        end
        StStart: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (i_busy) begin
            r_cnt   <= '0;
            r_state <= StRun;
          end else if (r_cnt == AckLast) begin
            r_state <= StErr;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRun: begin
          if (!i_busy) begin
            r_state <= StDone;
          end else if (r_cnt == RunLast) begin
            r_state <= StErr;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_done  <= r_grant;
          r_grant <= '0;
          r_ptr   <= r_idx;
          r_state <= StIdle;
        end
        StErr: begin
          // Placed after the clear above so a coincident abort keeps the flag set.
          r_done       <= r_grant;
          r_err        <= 1'b1;
          r_err_sticky <= 1'b1;
          r_grant      <= '0;
          r_ptr        <= r_idx;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Pulses held through disabled cycles surface once the enable returns.
  assign o_start      = r_start & i_en;
  assign o_done       = r_done & {N_REQ{i_en}};
  assign o_err        = r_err & i_en;
  assign o_err_sticky = r_err_sticky;
  assign o_grant      = r_grant;
  assign o_depth      = r_depth;

endmodule

// File: tb/tb_softmax_job_scheduler.sv
// Directed bench for softmax_job_scheduler: job-level model checked every cycle plus literal checks.
module tb_softmax_job_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AT = 4;
  localparam int RT = 1024;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_en = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N*DW-1:0]   i_req_depth = '0;
  logic              i_clr_err = 1'b0;
  logic              i_busy = 1'b0;
  logic [N-1:0]      o_grant, o_done;
  logic              o_err, o_err_sticky, o_start;
  logic [DW-1:0]     o_depth;

  always #5 clk = ~clk;

  softmax_job_scheduler #(
    .N_REQ(N), .DEPTH_W(DW), .ACK_TIMEOUT(AT), .RUN_TIMEOUT(RT)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_req(i_req), .i_req_depth(i_req_depth),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_err_sticky(o_err_sticky),
    .i_clr_err(i_clr_err), .o_start(o_start), .o_depth(o_depth), .i_busy(i_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int arb(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Job-level model: phase 0 idle, 1 issue start, 2 await ack, 3 running, 4 report.
  bit           m_valid = 0;
  int           m_owner = -1, m_ptr = N - 1, m_phase = 0, m_cnt = 0;
  bit           m_abort, m_start, m_err, m_sticky;
  logic [N-1:0] m_done;
  logic [DW-1:0] m_depth;
  logic [N-1:0] one_hot_base = 4'b0001;

  always @(posedge clk) begin
    if (!i_rst_n) begin
      m_valid = 1; m_owner = -1; m_ptr = N - 1; m_phase = 0; m_cnt = 0; m_abort = 0;
      m_start = 0; m_done = '0; m_err = 0; m_sticky = 0; m_depth = '0;
    end else if (i_en) begin
      m_start = 0; m_done = '0; m_err = 0;
      if (i_clr_err) m_sticky = 0;
      case (m_phase)
        0: begin
          m_owner = arb(i_req, m_ptr);
          if (m_owner >= 0) begin
            m_depth = i_req_depth[m_owner*DW +: DW];
            m_phase = 1;
          end
        end
        1: begin m_start = 1; m_cnt = 0; m_phase = 2; end
        2: if (i_busy) begin m_cnt = 0; m_phase = 3; end
           else begin
             m_cnt++;
             if (m_cnt == AT) begin m_abort = 1; m_phase = 4; end
           end
        3: if (!i_busy) begin m_abort = 0; m_phase = 4; end
           else begin
             m_cnt++;
             if (m_cnt == RT) begin m_abort = 1; m_phase = 4; end
           end
        default: begin
          m_done = one_hot_base << m_owner;
          m_err = m_abort;
          if (m_abort) m_sticky = 1;
          m_ptr = m_owner; m_owner = -1; m_phase = 0;
        end
      endcase
    end
  end

  // Compare and monitor, mid-cycle.
  int           n_neg = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int           last_start_n = 0, last_err_n = 0;
  logic [N-1:0] last_done_vec = '0, prev_grant = '0;
  logic         last_done_err = 0;
  int           grant_q[$], grant_n_q[$], done_n_q[$];

  always @(negedge clk) begin
    n_neg++;
    if (m_valid) begin
      check("grant", 32'(o_grant), 32'((m_owner >= 0) ? (one_hot_base << m_owner) : '0));
      check("start", 32'(o_start), 32'(m_start & i_en));
      check("done", 32'(o_done), 32'(m_done & {N{i_en}}));
      check("err", 32'(o_err), 32'(m_err & i_en));
      check("err_sticky", 32'(o_err_sticky), 32'(m_sticky));
      check("depth", 32'(o_depth), 32'(m_depth));
    end
    if (o_start === 1'b1) begin start_cnt++; last_start_n = n_neg; end
    if (|o_done) begin
      done_cnt++; last_done_vec = o_done; last_done_err = o_err; done_n_q.push_back(n_neg);
    end
    if (o_err === 1'b1) begin err_cnt++; last_err_n = n_neg; end
    if (o_grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (o_grant[i]) grant_q.push_back(i);
      grant_n_q.push_back(n_neg);
    end
    prev_grant = o_grant;
  end

  // Engine stand-in: 0 = ack after 2, busy 20; 1 = never busy; 2 = busy until o_done.
  int eng_mode = 0, eng_t = 0;
  bit eng_act = 0;
  always @(posedge clk) begin
    #3;
    case (eng_mode)
      0: begin
        if (!i_rst_n) eng_act = 0;
        else if (o_start) begin eng_act = 1; eng_t = 0; end
        else if (eng_act) eng_t++;
        i_busy = eng_act && eng_t >= 2 && eng_t < 22;
        if (eng_act && eng_t >= 22) eng_act = 0;
      end
      1: i_busy = 1'b0;
      default: begin
        if (o_start) i_busy = 1'b1;
        else if (|o_done) i_busy = 1'b0;
      end
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_done(input logic [N-1:0] drop, input int limit, input string nm);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (|o_done) begin seen = 1; i_req = i_req & ~drop; break; end
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_sig(input int which, input int limit, input string nm);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if ((which == 0 && |o_grant) || (which == 1 && i_busy)) begin seen = 1; break; end
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  int base_s, base_d, base_e;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    tick(3);
    @(negedge clk); #1;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_depth", 32'(o_depth), 32'd0);
    check("rst_sticky", 32'(o_err_sticky), 32'd0);
    i_rst_n = 1'b1;
    tick(2);

    // 1: single job on requester 2, depth 15; depth change after grant is ignored.
    i_req_depth = {8'd4, 8'd15, 8'd9, 8'd3};
    base_s = start_cnt; base_e = err_cnt; grant_q.delete(); grant_n_q.delete();
    i_req = 4'b0100;
    wait_sig(0, 20, "t1_grant_seen");
    i_req_depth[2*DW +: DW] = 8'd99;
    wait_done(4'b0100, 100, "t1_done_seen");
    check("t1_depth", 32'(o_depth), 32'd15);
    check("t1_start_once", 32'(start_cnt - base_s), 32'd1);
    check("t1_done_vec", 32'(last_done_vec), 32'b0100);
    check("t1_no_err", 32'(err_cnt - base_e), 32'd0);
    check("t1_grant_to_start", 32'(last_start_n - grant_n_q[0]), 32'd1);

    // 2: all four requesting after reset -> 0,1,2,3,0, each one cycle after the prior done.
    i_rst_n = 1'b0; tick(2); i_rst_n = 1'b1;
    grant_q.delete(); grant_n_q.delete(); done_n_q.delete();
    i_req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done((k == 4) ? 4'b1111 : 4'b0000, 100, "t2_done_seen");
    tick(1);
    check("t2_grant_count", 32'(grant_q.size()), 32'd5);
    for (int j = 0; j < 5 && j < grant_q.size(); j++) check("t2_order", 32'(grant_q[j]), 32'(exp_order[j]));
    for (int j = 1; j < 5 && j < grant_n_q.size(); j++) check("t2_regrant_gap", 32'(grant_n_q[j] - done_n_q[j-1]), 32'd1);

    // 3: engine never acknowledges -> abort, sticky until cleared.
    eng_mode = 1;
    i_req = 4'b0010;
    wait_done(4'b0010, 100, "t3_done_seen");
    check("t3_done_vec", 32'(last_done_vec), 32'b0010);
    check("t3_err_with_done", 32'(last_done_err), 32'd1);
    check("t3_start_to_err", 32'(last_err_n - last_start_n), 32'd5);
    tick(3);
    @(negedge clk); #1;
    check("t3_sticky_held", 32'(o_err_sticky), 32'd1);
    i_clr_err = 1'b1; tick(1); i_clr_err = 1'b0;
    @(negedge clk); #1;
    check("t3_sticky_cleared", 32'(o_err_sticky), 32'd0);

    // 4: busy stuck high -> run watchdog; requester 0 then served normally.
    eng_mode = 2;
    i_req = 4'b1001;
    wait_done(4'b1000, 1300, "t4_done_seen");
    check("t4_done_vec", 32'(last_done_vec), 32'b1000);
    check("t4_err_with_done", 32'(last_done_err), 32'd1);
    check("t4_start_to_err", 32'(last_err_n - last_start_n), 32'd1026);
    eng_mode = 0; eng_act = 0;
    wait_done(4'b0001, 100, "t4_next_done_seen");
    check("t4_next_done_vec", 32'(last_done_vec), 32'b0001);
    check("t4_next_no_err", 32'(last_done_err), 32'd0);

    // 5: enable dropped three cycles in START and in RUN.
    base_s = start_cnt; base_d = done_cnt;
    i_req = 4'b0100;
    wait_sig(0, 20, "t5_grant_seen");
    i_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 i_en = 1'b1;
    wait_sig(1, 20, "t5_busy_seen");
    repeat (5) @(negedge clk);
    #1 i_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 i_en = 1'b1;
    wait_done(4'b0100, 100, "t5_done_seen");
    check("t5_start_once", 32'(start_cnt - base_s), 32'd1);
    check("t5_done_once", 32'(done_cnt - base_d), 32'd1);
    check("t5_no_err", 32'(last_done_err), 32'd0);

    // 6: reset during RUN -> silent abort, pointer back to N-1.
    i_req = 4'b0010;
    wait_sig(1, 30, "t6_busy_seen");
    repeat (3) @(negedge clk);
    #1 i_rst_n = 1'b0; i_req = 4'b1111;
    base_d = done_cnt;
    @(negedge clk); #1;
    check("t6_rst_grant", 32'(o_grant), 32'd0);
    check("t6_rst_start", 32'(o_start), 32'd0);
    check("t6_rst_done", 32'(o_done), 32'd0);
    check("t6_rst_err", 32'(o_err), 32'd0);
    check("t6_rst_depth", 32'(o_depth), 32'd0);
    @(negedge clk); #1 i_rst_n = 1'b1;
    check("t6_no_done", 32'(done_cnt - base_d), 32'd0);
    wait_sig(0, 20, "t6_grant_seen");
    check("t6_first_grant", 32'(o_grant), 32'b0001);
    wait_done(4'b1111, 100, "t6_done_seen");
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
